// File: rtl/ft_fifo_flags.sv
// First-word fall-through FIFO with registered level and status flags.
// Optional sticky overflow/underflow reporting under macro FT_FIFO_FLAGS_ERR_EN.
module ft_fifo_flags #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AF_LVL = DEPTH - 2,
   parameter int unsigned AE_LVL = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             d_in,
   input  logic                         w_en,
   input  logic                         r_en,
   output logic [WIDTH-1:0]             d_out,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef FT_FIFO_FLAGS_ERR_EN
   ,
   input  logic                         err_clr,
   output logic                         ovf,
   output logic                         udf
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   logic             rd_acc;
   logic             wr_acc;
   logic [PW-1:0]    rd_ptr_nxt;
   logic [LW-1:0]    lvl_nxt;
   logic             head_is_new;
   logic [WIDTH-1:0] d_out_nxt;

   // Acceptance and next-state decode; flags and head word are precomputed so outputs stay registered
   always_comb begin
      rd_acc      = r_en && !empty;
      wr_acc      = w_en && (!full || rd_acc);
      rd_ptr_nxt  = rd_acc ? rd_ptr + PW'(1) : rd_ptr;
      lvl_nxt     = level;
      case ({wr_acc, rd_acc})
         2'b10:   lvl_nxt = level + LW'(1);
         2'b01:   lvl_nxt = level - LW'(1);
         default: lvl_nxt = level;
      endcase
      // The word written this cycle becomes the head when nothing older remains
      head_is_new = wr_acc && (level == (rd_acc ? LW'(1) : LW'(0)));
      if (lvl_nxt == LW'(0)) begin
         d_out_nxt = '0;
      end else if (head_is_new) begin
         d_out_nxt = d_in;
      end else begin
         d_out_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= d_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         d_out        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         rd_ptr       <= rd_ptr_nxt;
         level        <= lvl_nxt;
         d_out        <= d_out_nxt;
         full         <= (lvl_nxt == LW'(DEPTH));
         empty        <= (lvl_nxt == LW'(0));
         almost_full  <= (lvl_nxt >= LW'(AF_LVL));
         almost_empty <= (lvl_nxt <= LW'(AE_LVL));
      end
   end

`ifdef FT_FIFO_FLAGS_ERR_EN
   // Sticky error flags; a new event wins over a clear in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         ovf <= (w_en && !wr_acc) || (ovf && !err_clr);
         udf <= (r_en && empty)   || (udf && !err_clr);
      end
   end
`endif

endmodule

// File: doc/ft_fifo_flags.md
FT_FIFO_FLAGS -- requirements
Module: ft_fifo_flags

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning storage entries (power of two, >=4).
REQ-003 The block SHALL have parameter AF_LVL, default DEPTH-2, meaning almost_full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LVL, default 2, meaning almost_empty threshold (1..DEPTH-1).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning single clock, all state updates on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port d_in, input, WIDTH bits, meaning write data.
REQ-008 The block SHALL have port w_en, input, 1 bit, meaning write request.
REQ-009 The block SHALL have port r_en, input, 1 bit, meaning read/pop request for the head word.
REQ-010 The block SHALL have port d_out, output, WIDTH bits, meaning head word (first-word fall-through).
REQ-011 The block SHALL have ports full, empty, almost_full, almost_empty, output, 1 bit each, meaning status flags.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH+1) bits, meaning number of stored words.

Function
REQ-013 d_out SHALL present the oldest stored word whenever empty=0, without a read request, and SHALL be all-zero when empty=1.
REQ-014 A write SHALL be accepted when w_en=1 and (full=0 or a read is accepted in the same cycle).
REQ-015 A read SHALL be accepted when r_en=1 and empty=0; r_en while empty is ignored.
REQ-016 A word written at edge k SHALL appear on d_out (if it is the head) and clear empty immediately after edge k (latency 1 edge).
REQ-017 After an accepted read at edge k, d_out SHALL show the next word, or zero with empty=1, immediately after edge k.
REQ-018 level SHALL increment on write-only, decrement on read-only, and hold on simultaneous accepted write+read or no access.
REQ-019 Simultaneous w_en+r_en when empty SHALL accept the write only; level becomes 1.
REQ-020 Simultaneous w_en+r_en when full SHALL accept both; level stays DEPTH, full stays 1.
REQ-021 Flags SHALL be decoded from level: full=(level==DEPTH), empty=(level==0), almost_full=(level>=AF_LVL), almost_empty=(level<=AE_LVL).
REQ-022 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap or stall.
REQ-023 A rejected write SHALL leave memory, pointers and level unchanged.

Reset
REQ-024 When rst=1 at a rising edge, pointers and level SHALL clear to 0; after that edge empty=1, almost_empty=1, full=0, almost_full=0, d_out=0, level=0.
REQ-025 w_en and r_en SHALL be ignored on any edge where rst=1, including mid-operation; stored contents are discarded.
REQ-026 Memory array contents SHALL NOT require reset.

Configuration
REQ-027 With macro FT_FIFO_FLAGS_ERR_EN defined, the block SHALL add input err_clr (1 bit) and outputs ovf, udf (1 bit each), cleared by rst.
REQ-028 With FT_FIFO_FLAGS_ERR_EN defined, ovf SHALL set sticky on any rejected write, udf SHALL set sticky on r_en while empty, and both SHALL clear on err_clr=1; set wins over clear in the same cycle.
REQ-029 Without FT_FIFO_FLAGS_ERR_EN, ports err_clr, ovf and udf SHALL be absent and all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=8, AF_LVL=6, AE_LVL=2)
REQ-030 Reset then write 'T','e','s','t' -> d_out='T' one edge after first write, level=4, almost_empty=0 after 3rd write.
REQ-031 Write 8 words 0x01..0x08 -> full=1, almost_full=1 from level 6; 9th write 0xFF rejected, level=8, ovf=1 (ERR_EN).
REQ-032 From full, 5 cycles w_en+r_en with 0x10..0x14 -> level stays 8, d_out sequence 0x01..0x06, pointers wrap.
REQ-033 Drain to empty, then r_en -> empty=1, d_out=0x00, level=0, udf=1; err_clr pulse -> udf=0.
REQ-034 Empty FIFO, w_en+r_en with 0xA5 -> level=1, d_out=0xA5, empty=0.
REQ-035 Level 5, rst=1 with w_en=1 -> next edge level=0, empty=1, d_out=0x00, ovf=udf=0.
